// File: rtl/ll_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ll_pkg
// Description : Shared line-length pipeline definitions: default sample width
//               and a constant-evaluable ceil(log2) helper for derived widths.
// Revision    : 1.0 - initial release
// ============================================================================
package ll_pkg;

  // Width of the absolute-difference samples produced by ll_comp_unit
  localparam int LL_DATA_WIDTH = 32;

  // Ceiling log2; returns 0 for values <= 1
  function automatic int ll_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ll_ring_buf.sv
`default_nettype none
// ============================================================================
// Module      : ll_ring_buf
// Description : DEPTH x DATA_WIDTH sample store, one write port and one read
//               port with a registered read address (one-cycle read latency).
//               No reset, so it maps onto block RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module ll_ring_buf
  import ll_pkg::*;
#(
  parameter int DATA_WIDTH = LL_DATA_WIDTH,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = ll_clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_addr_q;

  // Write port: store the sample committed by the accumulator stage
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read port: capture the address; data appears on the following cycle
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rd_addr_q <= rd_addr_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_q];

endmodule
`default_nettype wire

// File: rtl/ll_window_acc.sv
`default_nettype none
// ============================================================================
// Module      : ll_window_acc
// Description : Sliding-window line-length accumulator. Keeps the last
//               WIN_LEN samples in a ring buffer, maintains their running sum
//               and emits it once the window is full, then every HOP accepts.
//               Two-stage pipeline: S1 reads the evicted slot, S2 updates the
//               sum and overwrites the slot.
// Revision    : 1.0 - initial release
// ============================================================================
module ll_window_acc
  import ll_pkg::*;
#(
  parameter  int DATA_WIDTH = LL_DATA_WIDTH,
  parameter  int WIN_LEN    = 256,
  parameter  int HOP        = 1,
  localparam int SUM_WIDTH  = DATA_WIDTH + ll_clog2(WIN_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  din_valid_i,
  output logic [SUM_WIDTH-1:0]  sum_out_o,
  output logic                  sum_valid_o,
  output logic                  win_full_o
);

  localparam int PTR_W  = ll_clog2(WIN_LEN);
  localparam int FILL_W = PTR_W + 1;
  localparam int HOP_W  = (HOP > 1) ? ll_clog2(HOP) : 1;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Control state
  state_t              state_q;
  logic [PTR_W-1:0]    wptr_q;
  logic [FILL_W-1:0]   fill_cnt_q;
  logic [HOP_W-1:0]    hop_cnt_q;

  // S1 pipeline registers
  logic                  s1_valid_q;
  logic [DATA_WIDTH-1:0] s1_data_q;
  logic [PTR_W-1:0]      s1_ptr_q;
  logic                  s1_old_zero_q;
  logic                  s1_emit_q;

  // S2 / output registers
  logic [SUM_WIDTH-1:0]  sum_q;
  logic [SUM_WIDTH-1:0]  sum_d;
  logic [SUM_WIDTH-1:0]  sum_out_q;
  logic                  sum_valid_q;
  logic                  win_full_q;

  // Combinational helpers
  logic                  fill_last;
  logic [HOP_W-1:0]      hop_cur;
  logic [HOP_W-1:0]      hop_cnt_d;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [SUM_WIDTH-1:0]  old_eff;
  logic                  buf_wr_en;

  // The accept that completes the window
  assign fill_last = (state_q == ST_FILL) && (fill_cnt_q == FILL_W'(WIN_LEN - 1));

  // Hop position of the current accept: the filling accept counts as position 0
  assign hop_cur   = (state_q == ST_RUN) ? hop_cnt_q : '0;
  assign hop_cnt_d = (hop_cur == HOP_W'(HOP - 1)) ? '0 : hop_cur + HOP_W'(1);

  // Slots read during FILL have not been written since reset, so they contribute nothing
  assign old_eff   = s1_old_zero_q ? '0 : SUM_WIDTH'(rd_data);
  assign sum_d     = sum_q + SUM_WIDTH'(s1_data_q) - old_eff;

  // A sample still in S1 when reset arrives must not reach the buffer
  assign buf_wr_en = s1_valid_q && !rst;

  ll_ring_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (WIN_LEN),
    .ADDR_WIDTH (PTR_W)
  ) u_ring_buf (
    .clk       (clk),
    .wr_en_i   (buf_wr_en),
    .wr_addr_i (s1_ptr_q),
    .wr_data_i (s1_data_q),
    .rd_en_i   (din_valid_i),
    .rd_addr_i (wptr_q),
    .rd_data_o (rd_data)
  );

  // FILL/RUN control and S1 capture: pointer advance, fill/hop counting, emit decision
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_FILL;
      wptr_q        <= '0;
      fill_cnt_q    <= '0;
      hop_cnt_q     <= '0;
      s1_valid_q    <= 1'b0;
      s1_old_zero_q <= 1'b0;
      s1_emit_q     <= 1'b0;
    end else begin
      s1_valid_q <= din_valid_i;
      if (din_valid_i) begin
        s1_data_q <= din_i;
        s1_ptr_q  <= wptr_q;
        wptr_q    <= wptr_q + PTR_W'(1);
        case (state_q)
          ST_FILL: begin
            s1_old_zero_q <= 1'b1;
            s1_emit_q     <= fill_last;
            fill_cnt_q    <= fill_cnt_q + FILL_W'(1);
            if (fill_last) begin
              state_q   <= ST_RUN;
              hop_cnt_q <= hop_cnt_d;
            end
          end
          ST_RUN: begin
            s1_old_zero_q <= 1'b0;
            s1_emit_q     <= (hop_cnt_q == '0);
            hop_cnt_q     <= hop_cnt_d;
          end
          default: begin
            state_q <= ST_FILL;
          end
        endcase
      end
    end
  end

  // S2: update the running sum and publish it on emit cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      sum_out_q   <= '0;
      sum_valid_q <= 1'b0;
      win_full_q  <= 1'b0;
    end else begin
      sum_valid_q <= s1_valid_q && s1_emit_q;
      if (s1_valid_q) begin
        sum_q <= sum_d;
        if (s1_emit_q) begin
          sum_out_q  <= sum_d;
          win_full_q <= 1'b1;
        end
      end
    end
  end

  assign sum_out_o   = sum_out_q;
  assign sum_valid_o = sum_valid_q;
  assign win_full_o  = win_full_q;

endmodule
`default_nettype wire

// File: tb/tb_ll_window_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_ll_window_acc
// Description : Directed checks of ll_window_acc: basic window, hop, gaps,
//               maximum value, reset mid-run and a random pointer-wrap stream
//               against a last-4-samples reference sum.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ll_window_acc;

  logic        clk;
  logic        rst;
  logic [31:0] din;
  logic        din_valid;

  logic [33:0] a_sum;
  logic        a_valid;
  logic        a_full;
  logic [33:0] b_sum;
  logic        b_valid;
  logic        b_full;
  logic [9:0]  c_sum;
  logic        c_valid;
  logic        c_full;

  int total;
  int bad;

  // window 4, hop 1, 32-bit samples
  ll_window_acc #(.DATA_WIDTH(32), .WIN_LEN(4), .HOP(1)) dut_a (
    .clk(clk), .rst(rst), .din_i(din), .din_valid_i(din_valid),
    .sum_out_o(a_sum), .sum_valid_o(a_valid), .win_full_o(a_full));

  // window 4, hop 2
  ll_window_acc #(.DATA_WIDTH(32), .WIN_LEN(4), .HOP(2)) dut_b (
    .clk(clk), .rst(rst), .din_i(din), .din_valid_i(din_valid),
    .sum_out_o(b_sum), .sum_valid_o(b_valid), .win_full_o(b_full));

  // window 4, hop 1, 8-bit samples
  ll_window_acc #(.DATA_WIDTH(8), .WIN_LEN(4), .HOP(1)) dut_c (
    .clk(clk), .rst(rst), .din_i(din[7:0]), .din_valid_i(din_valid),
    .sum_out_o(c_sum), .sum_valid_o(c_valid), .win_full_o(c_full));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input int sel, input logic ev, input logic [63:0] es,
                            input logic ef, input string tag);
    logic        ov;
    logic [63:0] os;
    logic        of;
    case (sel)
      0:       begin ov = a_valid; os = 64'(a_sum); of = a_full; end
      1:       begin ov = b_valid; os = 64'(b_sum); of = b_full; end
      default: begin ov = c_valid; os = 64'(c_sum); of = c_full; end
    endcase
    chk({tag, ".sum_valid"}, 64'(ov), 64'(ev));
    chk({tag, ".sum_out"},   os,      es);
    chk({tag, ".win_full"},  64'(of), 64'(ef));
  endtask

  // One clock with the given input; outputs then reflect the previous call's sample
  task automatic cyc(input int sel, input logic v, input logic [31:0] d, input logic ev,
                     input logic [63:0] es, input logic ef, input string tag);
    din_valid = v;
    din       = d;
    @(posedge clk);
    #1;
    check_outs(sel, ev, es, ef, tag);
  endtask

  // One reset cycle; outputs must be at reset values right after it
  task automatic rst_cyc(input int sel, input string tag);
    rst       = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    @(posedge clk);
    #1;
    check_outs(sel, 1'b0, 64'd0, 1'b0, tag);
    rst = 1'b0;
  endtask

  logic [63:0] hist [4];
  int          h_idx;
  int          cnt;
  int          acc;
  logic        v;
  logic [31:0] d;
  logic        cur_v, prev_v, full;
  logic [63:0] cur_s, prev_s, hold;
  int          gap_exp [1:6];

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    @(posedge clk);
    #1;
    check_outs(0, 1'b0, 64'd0, 1'b0, "reset_a");
    check_outs(1, 1'b0, 64'd0, 1'b0, "reset_b");
    check_outs(2, 1'b0, 64'd0, 1'b0, "reset_c");
    rst = 1'b0;

    // Basic window: 1..6 back to back
    cyc(0, 1, 1, 0, 0, 0, "basic1");
    cyc(0, 1, 2, 0, 0, 0, "basic2");
    cyc(0, 1, 3, 0, 0, 0, "basic3");
    cyc(0, 1, 4, 0, 0, 0, "basic4");
    cyc(0, 1, 5, 1, 10, 1, "basic_s4");
    cyc(0, 1, 6, 1, 14, 1, "basic_s5");
    cyc(0, 0, 0, 1, 18, 1, "basic_s6");
    cyc(0, 0, 0, 0, 18, 1, "basic_hold");

    // Hop 2: 1..8 back to back, pulses after 4, 6, 8
    rst_cyc(1, "hop_rst");
    cyc(1, 1, 1, 0, 0, 0, "hop1");
    cyc(1, 1, 2, 0, 0, 0, "hop2");
    cyc(1, 1, 3, 0, 0, 0, "hop3");
    cyc(1, 1, 4, 0, 0, 0, "hop4");
    cyc(1, 1, 5, 1, 10, 1, "hop_s4");
    cyc(1, 1, 6, 0, 10, 1, "hop_s5");
    cyc(1, 1, 7, 1, 18, 1, "hop_s6");
    cyc(1, 1, 8, 0, 18, 1, "hop_s7");
    cyc(1, 0, 0, 1, 26, 1, "hop_s8");
    cyc(1, 0, 0, 0, 26, 1, "hop_hold");

    // Gaps: 3 idle cycles between samples, pulse exactly 2 cycles after its accept
    gap_exp = '{0, 0, 0, 10, 14, 18};
    rst_cyc(0, "gap_rst");
    for (int k = 1; k <= 6; k++) begin
      cyc(0, 1, 32'(k), 0, (k > 4) ? 64'(gap_exp[k-1]) : 64'd0, k > 4, "gap_accept");
      cyc(0, 0, 0, k >= 4, 64'(gap_exp[k]), k >= 4, "gap_t2");
      cyc(0, 0, 0, 0, 64'(gap_exp[k]), k >= 4, "gap_t3");
      cyc(0, 0, 0, 0, 64'(gap_exp[k]), k >= 4, "gap_t4");
    end

    // Maximum value on an 8-bit window
    rst_cyc(2, "max_rst");
    cyc(2, 1, 255, 0, 0, 0, "max1");
    cyc(2, 1, 255, 0, 0, 0, "max2");
    cyc(2, 1, 255, 0, 0, 0, "max3");
    cyc(2, 1, 255, 0, 0, 0, "max4");
    cyc(2, 1, 255, 1, 1020, 1, "max_s4");
    cyc(2, 1, 255, 1, 1020, 1, "max_s5");
    cyc(2, 0, 0, 1, 1020, 1, "max_s6");
    cyc(2, 0, 0, 0, 1020, 1, "max_hold");
    rst_cyc(2, "half_rst");
    cyc(2, 1, 128, 0, 0, 0, "half1");
    cyc(2, 1, 128, 0, 0, 0, "half2");
    cyc(2, 1, 128, 0, 0, 0, "half3");
    cyc(2, 1, 128, 0, 0, 0, "half4");
    cyc(2, 0, 0, 1, 512, 1, "half_s4");
    cyc(2, 0, 0, 0, 512, 1, "half_hold");

    // Reset in the cycle after sample 5; stale buffer must be ignored after
    rst_cyc(0, "rmid_rst0");
    cyc(0, 1, 1, 0, 0, 0, "rmid1");
    cyc(0, 1, 2, 0, 0, 0, "rmid2");
    cyc(0, 1, 3, 0, 0, 0, "rmid3");
    cyc(0, 1, 4, 0, 0, 0, "rmid4");
    cyc(0, 1, 5, 1, 10, 1, "rmid_s4");
    rst_cyc(0, "rmid_rst");
    cyc(0, 0, 0, 0, 0, 0, "rmid_no_s5");
    cyc(0, 1, 7, 0, 0, 0, "rmid7a");
    cyc(0, 1, 7, 0, 0, 0, "rmid7b");
    cyc(0, 1, 7, 0, 0, 0, "rmid7c");
    cyc(0, 1, 7, 0, 0, 0, "rmid7d");
    cyc(0, 0, 0, 1, 28, 1, "rmid_first");
    cyc(0, 0, 0, 0, 28, 1, "rmid_hold");

    // Pointer wrap: random stream against a last-4 reference sum
    rst_cyc(0, "rand_rst");
    for (int i = 0; i < 4; i++) hist[i] = '0;
    h_idx  = 0;
    cnt    = 0;
    acc    = 0;
    prev_v = 1'b0;
    prev_s = '0;
    hold   = '0;
    full   = 1'b0;
    while (acc < 1000) begin
      v     = ($urandom_range(0, 3) != 0);
      d     = $urandom & 32'h7fff_ffff;
      cur_v = 1'b0;
      cur_s = '0;
      if (v) begin
        hist[h_idx] = 64'(d);
        h_idx       = (h_idx + 1) % 4;
        cnt++;
        acc++;
        cur_v = (cnt >= 4);
        cur_s = hist[0] + hist[1] + hist[2] + hist[3];
      end
      if (prev_v) begin
        hold = prev_s;
        full = 1'b1;
      end
      cyc(0, v, d, prev_v, hold, full, "rand");
      prev_v = cur_v;
      prev_s = cur_s;
    end
    if (prev_v) begin
      hold = prev_s;
      full = 1'b1;
    end
    cyc(0, 0, 0, prev_v, hold, full, "rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ll_window_acc.md
# ll_window_acc

Sliding-window line-length accumulator, the consumer end of the line-length difference stream. Takes one absolute-difference sample per `din_valid` from `ll_comp_unit` (`dout`/`data_valid`). Keeps the last `win_len` samples in a ring buffer and maintains their running sum. Emits the windowed line-length feature once the window is full, then every `hop` accepted samples, toward the feature/threshold stage.

## Interface
- `data_width`, 32: width of each incoming sample.
- `win_len`, 256: window length in samples. Must be a power of two, at least 4.
- `hop`, 1: accepted samples between consecutive outputs once the window is full. Range 1..`win_len`.
- `sum_width`, `data_width`+log2(`win_len`): accumulator and output width (derived; never overridden).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `din`  in  `data_width`  sample. Interpreted as an unsigned magnitude.
- `din_valid`  in  1  `din` is accepted this cycle. May be high every cycle.
- `sum_out`  out  `sum_width`  windowed sum of the last `win_len` accepted samples.
- `sum_valid`  out  1  one-cycle pulse; `sum_out` is valid this cycle.
- `win_full`  out  1  level; high once `win_len` samples have been accepted since reset.

## Operation
- **Reset values:** `sum_out`=0, `sum_valid`=0, `win_full`=0. Internal sum, write pointer, fill count and hop count all reset to 0. Buffer contents are not cleared.
- **States:**
  - FILL: fill count < `win_len`.
  - RUN: window full.
  - FILL→RUN on the accept that makes fill count = `win_len`. No return except by `rst`.
- **Per accepted sample, in two pipeline stages:**
  - S1: read `old` = buf[wptr]; register `din` and wptr; advance wptr modulo `win_len` (wraps `win_len`-1→0).
  - S2: `sum` ← `sum` + `din` − `old_eff`, then write buf[wptr_S1] ← `din`.
  - In FILL, `old_eff` = 0, because the slot has not been written since reset. In RUN, `old_eff` = `old`.
- **Width rules:** all arithmetic is unsigned at `sum_width`. The sum can never overflow or go negative. `din` = 2^(`data_width`−1), which `ll_comp_unit` produces for the most-negative wrap case, is accumulated as that unsigned value.
- **Output decision:**
  - The hop counter counts accepts only in RUN. It is 0 on the accept that fills the window and wraps at `hop`−1.
  - `sum_valid` pulses in S2 when the sample is the window-filling accept, or when the hop counter is 0 in RUN.
  - `sum_out` holds its value between pulses.
- **`win_full`** rises in the same cycle as the first `sum_valid`.
- **Back-to-back accepts:** the S1 read of wptr+1 and the S2 write of wptr are always different addresses, since `win_len` ≥ 4. No bypass is needed.
- **Gaps:** `din_valid` low means no state change. The pipeline drains normally.
- **Reset mid-operation:** any in-flight S1/S2 sample is discarded. No `sum_valid` follows the reset. The next accept starts FILL from slot 0.

## Timing
- `din_valid` high in cycle t → that sample is reflected in `sum_out`/`sum_valid` at cycle t+2, i.e. after 2 clock edges.
- Throughput: one sample per cycle.
- First `sum_valid`: 2 cycles after the `win_len`-th accept following reset.
- `rst` asserted in cycle t → outputs are at reset values from t+1.

## Structure
- Shared package `ll_pkg`: `LL_DATA_WIDTH` default, and a `clog2`-style helper for `sum_width`/pointer widths.
- The FILL/RUN enum is local to this block.
- Sub-module `ll_ring_buf`: single-port-write, single-read RAM of `win_len`×`data_width` with registered read address. Synchronous read, one-cycle latency, no reset. Infers block RAM.

## Test plan
1. **Basic window:** `win_len`=4, `hop`=1; accept 1,2,3,4,5,6 back-to-back.
   - → `sum_valid` pulses with `sum_out` 10, 14, 18 at t+2 of samples 4, 5, 6.
   - → `win_full` rises with the first pulse.
2. **Hop:** `win_len`=4, `hop`=2; accept 1..8.
   - → pulses only after samples 4, 6, 8, with values 10, 18, 26.
3. **Gaps:** same stimulus as scenario 1 with `din_valid` low for 3 cycles between every sample.
   - → identical sum sequence; each pulse arrives 2 cycles after its accept.
4. **Maximum value:** `win_len`=4, `data_width`=8; accept 255 ×6.
   - → every output = 1020, with no wrap.
   - → `din`=128 ×4 gives 512.
5. **Reset mid-run:** scenario 1 with `rst` asserted in the cycle after sample 5 is accepted.
   - → no pulse for sample 5.
   - → then accept 7,7,7,7; the first pulse is 28, proving stale buffer contents are ignored in FILL.
6. **Pointer wrap:** `win_len`=4; random stream of 1000 values, each < 2^31, with random `din_valid`.
   - → every `sum_out` matches a reference model's sum of the last 4 accepted samples, checked across many wraps.
